mem_port_arbiter: RTL and testbench

Shares the single external memory port between instruction fetch and the load/store path driven by the control unit's MEM_READ / MEM_WRITE decode. A three-phase FSM grants the port to one requester at a time, with fixed priority to data accesses. It generates byte enables and store-lane replication from FUNC3, and sign- or zero-extends load data. It stalls each requester through a BUSYWAIT until its access completes.

---
 rtl/mem_port_arbiter_if.sv | 38 +++
 rtl/mem_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-side signal bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  if_read;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic [31:0]           if_rdata;
    logic                  if_busywait;

    logic                  d_read;
    logic                  d_write;
    logic [2:0]            d_func3;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [31:0]           d_wdata;
    logic [31:0]           d_rdata;
    logic                  d_busywait;
    logic                  d_misaligned;

    logic                  m_read;
    logic                  m_write;
    logic [ADDR_WIDTH-1:0] m_addr;
    logic [31:0]           m_wdata;
    logic [3:0]            m_byte_en;
    logic [31:0]           m_rdata;
    logic                  m_ready;

    modport slave (
        input  if_read, if_addr, d_read, d_write, d_func3, d_addr, d_wdata, m_rdata, m_ready,
        output if_rdata, if_busywait, d_rdata, d_busywait, d_misaligned,
               m_read, m_write, m_addr, m_wdata, m_byte_en
    );

    modport master (
        output if_read, if_addr, d_read, d_write, d_func3, d_addr, d_wdata, m_rdata, m_ready,
        input  if_rdata, if_busywait, d_rdata, d_busywait, d_misaligned,
               m_read, m_write, m_addr, m_wdata, m_byte_en
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and load/store, data has priority
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    mem_port_arbiter_if.slave  bus_if
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        D_BUSY = 3'd1,
        I_BUSY = 3'd2,
        D_DONE = 3'd3,
        I_DONE = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]            func3_q, func3_d;
    logic                  wr_q, wr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            be_q, be_d;
    logic [31:0]           if_rdata_q, if_rdata_d;
    logic [31:0]           d_rdata_q, d_rdata_d;
    logic                  mis_q, mis_d;

    logic        d_req;
    logic        in_byte, in_half, misaligned;
    logic [3:0]  in_be;
    logic [31:0] in_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    assign d_req = bus_if.d_read | bus_if.d_write;

    // FUNC3[1:0] carries the size; any undefined encoding falls through to word
    always_comb begin
        in_byte    = (bus_if.d_func3[1:0] == 2'b00);
        in_half    = (bus_if.d_func3[1:0] == 2'b01);
        misaligned = (in_half && bus_if.d_addr[0]) ||
                     (!in_byte && !in_half && (bus_if.d_addr[1:0] != 2'b00));
        in_be      = 4'b1111;
        in_wdata   = bus_if.d_wdata;
        if (in_byte) begin
            in_wdata = {4{bus_if.d_wdata[7:0]}};
            if (bus_if.d_write) in_be = 4'b0001 << bus_if.d_addr[1:0];
        end else if (in_half) begin
            in_wdata = {2{bus_if.d_wdata[15:0]}};
            if (bus_if.d_write) in_be = bus_if.d_addr[1] ? 4'b1100 : 4'b0011;
        end
    end

    always_comb begin
        ld_byte = bus_if.m_rdata[7:0];
        case (addr_q[1:0])
            2'd0:    ld_byte = bus_if.m_rdata[7:0];
            2'd1:    ld_byte = bus_if.m_rdata[15:8];
            2'd2:    ld_byte = bus_if.m_rdata[23:16];
            default: ld_byte = bus_if.m_rdata[31:24];
        endcase
        ld_half = addr_q[1] ? bus_if.m_rdata[31:16] : bus_if.m_rdata[15:0];
        if (func3_q[1:0] == 2'b00)
            ld_ext = {{24{ld_byte[7] & ~func3_q[2]}}, ld_byte};
        else if (func3_q[1:0] == 2'b01)
            ld_ext = {{16{ld_half[15] & ~func3_q[2]}}, ld_half};
        else
            ld_ext = bus_if.m_rdata;
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        func3_d    = func3_q;
        wr_d       = wr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        mis_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (d_req) begin
                    addr_d  = bus_if.d_addr;
                    func3_d = bus_if.d_func3;
                    wr_d    = bus_if.d_write;
                    wdata_d = in_wdata;
                    be_d    = in_be;
                    if (misaligned) begin
                        state_d   = D_DONE;
                        mis_d     = 1'b1;
                        d_rdata_d = '0;
                    end else begin
                        state_d = D_BUSY;
                    end
                end else if (bus_if.if_read) begin
                    addr_d  = bus_if.if_addr;
                    wr_d    = 1'b0;
                    be_d    = 4'b1111;
                    state_d = I_BUSY;
                end
            end
            D_BUSY: begin
                if (bus_if.m_ready) begin
                    state_d = D_DONE;
                    if (!wr_q) d_rdata_d = ld_ext;
                end
            end
            I_BUSY: begin
                if (bus_if.m_ready) begin
                    state_d    = I_DONE;
                    if_rdata_d = bus_if.m_rdata;
                end
            end
            D_DONE:  state_d = IDLE;
            I_DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            func3_q    <= '0;
            wr_q       <= 1'b0;
            wdata_q    <= '0;
            be_q       <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            func3_q    <= func3_d;
            wr_q       <= wr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            mis_q      <= mis_d;
        end
    end

    // Strobes decode straight from state so an asynchronous reset kills them at once
    assign bus_if.m_read       = (state_q == I_BUSY) || ((state_q == D_BUSY) && !wr_q);
    assign bus_if.m_write      = (state_q == D_BUSY) && wr_q;
    assign bus_if.m_addr       = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign bus_if.m_wdata      = wdata_q;
    assign bus_if.m_byte_en    = be_q;
    assign bus_if.if_rdata     = if_rdata_q;
    assign bus_if.d_rdata      = d_rdata_q;
    assign bus_if.d_misaligned = mis_q;
    assign bus_if.if_busywait  = bus_if.if_read & (state_q != I_DONE);
    assign bus_if.d_busywait   = d_req & (state_q != D_DONE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    mem_port_arbiter_if #(.ADDR_WIDTH(32)) bus ();

    mem_port_arbiter #(.ADDR_WIDTH(32)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] exp);
        bus.d_read  = 1'b1;
        bus.d_func3 = f3;
        bus.d_addr  = addr;
        step();
        chk({tag, "_strobe"}, {31'd0, bus.m_read}, 32'd1);
        step();
        chk(tag, bus.d_rdata, exp);
        bus.d_read = 1'b0;
        step();
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n        = 1'b0;
        bus.if_read  = 1'b1;
        bus.if_addr  = '0;
        bus.d_read   = 1'b0;
        bus.d_write  = 1'b0;
        bus.d_func3  = 3'b010;
        bus.d_addr   = '0;
        bus.d_wdata  = '0;
        bus.m_rdata  = '0;
        bus.m_ready  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_m_read", {31'd0, bus.m_read}, 32'd0);
        chk("rst_m_write", {31'd0, bus.m_write}, 32'd0);
        chk("rst_m_addr", bus.m_addr, 32'd0);
        chk("rst_m_wdata", bus.m_wdata, 32'd0);
        chk("rst_m_be", {28'd0, bus.m_byte_en}, 32'd0);
        chk("rst_if_rdata", bus.if_rdata, 32'd0);
        chk("rst_d_rdata", bus.d_rdata, 32'd0);
        chk("rst_mis", {31'd0, bus.d_misaligned}, 32'd0);
        chk("rst_if_bw", {31'd0, bus.if_busywait}, 32'd1);
        bus.if_read = 1'b0;
        rst_n = 1'b1;
        step();

        // fetch only, memory ready in first strobe cycle
        bus.if_read = 1'b1;
        bus.if_addr = 32'h104;
        bus.m_ready = 1'b1;
        bus.m_rdata = 32'h00A00093;
        step();
        chk("f_m_read", {31'd0, bus.m_read}, 32'd1);
        chk("f_m_addr", bus.m_addr, 32'h104);
        chk("f_if_bw1", {31'd0, bus.if_busywait}, 32'd1);
        step();
        chk("f_m_read_done", {31'd0, bus.m_read}, 32'd0);
        chk("f_if_bw2", {31'd0, bus.if_busywait}, 32'd0);
        chk("f_if_rdata", bus.if_rdata, 32'h00A00093);
        bus.if_read = 1'b0;
        step();

        // simultaneous fetch and load word, data wins
        bus.if_read = 1'b1;
        bus.if_addr = 32'h108;
        bus.d_read  = 1'b1;
        bus.d_func3 = 3'b010;
        bus.d_addr  = 32'h200;
        bus.m_rdata = 32'h11223344;
        step();
        chk("s_d_strobe", {31'd0, bus.m_read}, 32'd1);
        chk("s_d_addr", bus.m_addr, 32'h200);
        chk("s_d_be", {28'd0, bus.m_byte_en}, 32'hF);
        chk("s_if_bw_a", {31'd0, bus.if_busywait}, 32'd1);
        chk("s_d_bw_a", {31'd0, bus.d_busywait}, 32'd1);
        step();
        chk("s_d_bw_done", {31'd0, bus.d_busywait}, 32'd0);
        chk("s_d_rdata", bus.d_rdata, 32'h11223344);
        chk("s_if_bw_b", {31'd0, bus.if_busywait}, 32'd1);
        chk("s_no_strobe_done", {31'd0, bus.m_read}, 32'd0);
        bus.d_read = 1'b0;
        step();
        chk("s_idle_gap", {31'd0, bus.m_read}, 32'd0);
        chk("s_if_bw_c", {31'd0, bus.if_busywait}, 32'd1);
        step();
        chk("s_i_strobe", {31'd0, bus.m_read}, 32'd1);
        chk("s_i_addr", bus.m_addr, 32'h108);
        step();
        chk("s_if_rdata", bus.if_rdata, 32'h11223344);
        chk("s_if_bw_done", {31'd0, bus.if_busywait}, 32'd0);
        bus.if_read = 1'b0;
        step();

        // byte store then back-to-back halfword store
        bus.d_write = 1'b1;
        bus.d_func3 = 3'b000;
        bus.d_addr  = 32'h203;
        bus.d_wdata = 32'h1234565A;
        step();
        chk("sb_m_write", {31'd0, bus.m_write}, 32'd1);
        chk("sb_m_read", {31'd0, bus.m_read}, 32'd0);
        chk("sb_be", {28'd0, bus.m_byte_en}, 32'h8);
        chk("sb_wdata", bus.m_wdata, 32'h5A5A5A5A);
        chk("sb_addr", bus.m_addr, 32'h200);
        step();
        chk("sb_done_strobe", {31'd0, bus.m_write}, 32'd0);
        chk("sb_d_bw", {31'd0, bus.d_busywait}, 32'd0);
        bus.d_func3 = 3'b001;
        bus.d_addr  = 32'h202;
        bus.d_wdata = 32'hABCDBEEF;
        step();
        chk("sh_idle_gap", {31'd0, bus.m_write}, 32'd0);
        chk("sh_idle_bw", {31'd0, bus.d_busywait}, 32'd1);
        step();
        chk("sh_m_write", {31'd0, bus.m_write}, 32'd1);
        chk("sh_be", {28'd0, bus.m_byte_en}, 32'hC);
        chk("sh_wdata", bus.m_wdata, 32'hBEEFBEEF);
        chk("sh_addr", bus.m_addr, 32'h200);
        step();
        bus.d_write = 1'b0;
        step();

        // load extension
        bus.m_rdata = 32'h80FF7F01;
        run_load("lb_202", 3'b000, 32'h202, 32'hFFFFFFFF);
        run_load("lbu_203", 3'b100, 32'h203, 32'h00000080);
        run_load("lh_200", 3'b001, 32'h200, 32'h00007F01);
        run_load("lh_202", 3'b001, 32'h202, 32'hFFFF80FF);
        run_load("lhu_202", 3'b101, 32'h202, 32'h000080FF);

        // misaligned word load
        bus.d_read  = 1'b1;
        bus.d_func3 = 3'b010;
        bus.d_addr  = 32'h201;
        step();
        chk("mis_no_read", {31'd0, bus.m_read}, 32'd0);
        chk("mis_pulse", {31'd0, bus.d_misaligned}, 32'd1);
        chk("mis_rdata", bus.d_rdata, 32'd0);
        chk("mis_d_bw", {31'd0, bus.d_busywait}, 32'd0);
        bus.d_read = 1'b0;
        step();
        chk("mis_pulse_end", {31'd0, bus.d_misaligned}, 32'd0);
        chk("mis_idle_read", {31'd0, bus.m_read}, 32'd0);

        // three memory wait cycles on a fetch
        bus.if_read = 1'b1;
        bus.if_addr = 32'h300;
        bus.m_ready = 1'b0;
        bus.m_rdata = 32'hDEADBEEF;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("w_m_read", {31'd0, bus.m_read}, 32'd1);
            chk("w_m_addr", bus.m_addr, 32'h300);
            chk("w_if_bw", {31'd0, bus.if_busywait}, 32'd1);
            if (i == 3) bus.m_ready = 1'b1;
            step();
        end
        chk("w_done_read", {31'd0, bus.m_read}, 32'd0);
        chk("w_done_bw", {31'd0, bus.if_busywait}, 32'd0);
        chk("w_if_rdata", bus.if_rdata, 32'hDEADBEEF);
        bus.if_read = 1'b0;
        bus.m_ready = 1'b0;
        step();

        // reset asserted during a stalled store
        bus.d_write = 1'b1;
        bus.d_func3 = 3'b010;
        bus.d_addr  = 32'h400;
        bus.d_wdata = 32'hCAFEF00D;
        step();
        chk("r_m_write_before", {31'd0, bus.m_write}, 32'd1);
        chk("r_wdata_before", bus.m_wdata, 32'hCAFEF00D);
        #2;
        rst_n = 1'b0;
        #1;
        chk("r_m_write_async", {31'd0, bus.m_write}, 32'd0);
        chk("r_m_addr_async", bus.m_addr, 32'd0);
        chk("r_m_wdata_async", bus.m_wdata, 32'd0);
        chk("r_d_bw_in_rst", {31'd0, bus.d_busywait}, 32'd1);
        @(negedge clk);
        bus.d_write = 1'b0;
        rst_n = 1'b1;
        step();
        chk("r_idle_write", {31'd0, bus.m_write}, 32'd0);
        chk("r_idle_read", {31'd0, bus.m_read}, 32'd0);
        chk("r_idle_mis", {31'd0, bus.d_misaligned}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
